// File: rtl/exc_ctrl.sv
// Exception/interrupt/ertn sequencer between WB, the CSR file and pre-IF.
// Picks one event per WB instruction, strobes the CSR, flushes, then redirects.
module exc_ctrl #(
  parameter int PC_W   = 32,
  parameter bit INT_EN = 1'b1
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            wb_valid,
  output logic            wb_ready,
  input  logic [PC_W-1:0] wb_pc,
  input  logic [4:0]      wb_exc,
  input  logic            wb_ertn,
  output logic            wb_commit,
  input  logic            has_int,
  input  logic [PC_W-1:0] ex_entry,
  input  logic [PC_W-1:0] ertn_pc,
  output logic            csr_wb_ex,
  output logic [5:0]      csr_ecode,
  output logic [8:0]      csr_esubcode,
  output logic [PC_W-1:0] csr_pc,
  output logic            csr_ertn_flush,
  output logic            pipe_flush,
  output logic            redirect_valid,
  output logic [PC_W-1:0] redirect_target,
  input  logic            redirect_ready
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_COMMIT   = 2'd1,
    S_WAIT     = 2'd2,
    S_REDIRECT = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [1:0]      r_rstSync;
  logic            r_isErtn;
  logic [5:0]      r_ecode;
  logic [8:0]      r_esubcode;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] r_target;

  logic            w_rstDone;
  logic            w_intP;
  logic            w_anyExc;
  logic            w_evt;
  logic [5:0]      w_ecode;
  logic [8:0]      w_esubcode;

  // Reset asserts asynchronously but releases only after two clean edges.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_rstSync <= 2'b00;
    else         r_rstSync <= {r_rstSync[0], 1'b1};
  end

  assign w_rstDone = r_rstSync[1];
  assign w_intP    = INT_EN & has_int;
  assign w_anyExc  = w_intP | (|wb_exc);
  assign w_evt     = w_rstDone & wb_valid & (w_anyExc | wb_ertn);

  always_comb begin
    w_ecode    = 6'h00;
    w_esubcode = 9'd0;
    if (w_intP)         w_ecode = 6'h00;
    else if (wb_exc[0]) w_ecode = 6'h08;
    else if (wb_exc[1]) w_ecode = 6'h0D;
    else if (wb_exc[2]) w_ecode = 6'h0B;
    else if (wb_exc[3]) w_ecode = 6'h0C;
    else if (wb_exc[4]) w_ecode = 6'h09;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Event details are frozen in IDLE; the redirect target is sampled while in WAIT
  // so that the CSR write from COMMIT has already landed.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_isErtn   <= 1'b0;
      r_ecode    <= 6'h00;
      r_esubcode <= 9'd0;
      r_pc       <= '0;
      r_target   <= '0;
    end else begin
      if (r_state == S_IDLE && w_evt) begin
        r_isErtn   <= ~w_anyExc;
        r_ecode    <= w_ecode;
        r_esubcode <= w_esubcode;
        r_pc       <= wb_pc;
      end
      if (r_state == S_WAIT) r_target <= r_isErtn ? ertn_pc : ex_entry;
    end
  end

  always_comb begin
    w_next          = r_state;
    wb_ready        = 1'b0;
    wb_commit       = 1'b0;
    csr_wb_ex       = 1'b0;
    csr_ecode       = 6'h00;
    csr_esubcode    = 9'd0;
    csr_pc          = '0;
    csr_ertn_flush  = 1'b0;
    pipe_flush      = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = '0;
    case (r_state)
      S_IDLE: begin
        wb_ready  = 1'b1;
        wb_commit = w_rstDone & wb_valid & ~w_evt;
        if (w_evt) w_next = S_COMMIT;
      end
      S_COMMIT: begin
        pipe_flush = 1'b1;
        if (r_isErtn) begin
          csr_ertn_flush = 1'b1;
        end else begin
          csr_wb_ex    = 1'b1;
          csr_ecode    = r_ecode;
          csr_esubcode = r_esubcode;
          csr_pc       = r_pc;
        end
        w_next = S_WAIT;
      end
      S_WAIT: begin
        pipe_flush = 1'b1;
        w_next     = S_REDIRECT;
      end
      S_REDIRECT: begin
        pipe_flush      = 1'b1;
        redirect_valid  = 1'b1;
        redirect_target = r_target;
        if (redirect_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_exc_ctrl.sv
// Randomized self-checking bench for exc_ctrl: one instance with interrupts enabled,
// one with them disabled, both checked every cycle against a cycle-count reference model.
module tb_exc_ctrl;

  localparam int PC_W = 32;

  logic            clk = 1'b0;
  logic            resetn;
  logic            wb_valid;
  logic [PC_W-1:0] wb_pc;
  logic [4:0]      wb_exc;
  logic            wb_ertn;
  logic            has_int;
  logic [PC_W-1:0] ex_entry;
  logic [PC_W-1:0] ertn_pc;
  logic            redirect_ready;

  typedef struct packed {
    logic        wbReady;
    logic        wbCommit;
    logic        csrWbEx;
    logic [5:0]  ecode;
    logic [8:0]  esub;
    logic [31:0] csrPc;
    logic        ertnFlush;
    logic        pipeFlush;
    logic        redValid;
    logic [31:0] redTarget;
  } outs_t;

  logic        wbReady0, wbCommit0, csrWbEx0, ertnFlush0, pipeFlush0, redValid0;
  logic [5:0]  ecode0;
  logic [8:0]  esub0;
  logic [31:0] csrPc0, redTarget0;
  logic        wbReady1, wbCommit1, csrWbEx1, ertnFlush1, pipeFlush1, redValid1;
  logic [5:0]  ecode1;
  logic [8:0]  esub1;
  logic [31:0] csrPc1, redTarget1;

  outs_t obs [2];
  assign obs[0] = {wbReady0, wbCommit0, csrWbEx0, ecode0, esub0, csrPc0, ertnFlush0, pipeFlush0, redValid0, redTarget0};
  assign obs[1] = {wbReady1, wbCommit1, csrWbEx1, ecode1, esub1, csrPc1, ertnFlush1, pipeFlush1, redValid1, redTarget1};

  int errCnt   = 0;
  int checkCnt = 0;

  // Reference model: age counts cycles since the event was accepted (-1 = idle).
  int          mAge   [2];
  logic        mErtn  [2];
  logic [5:0]  mEcode [2];
  logic [31:0] mPc    [2];
  logic [31:0] mTgt   [2];

  always #5 clk = ~clk;

  exc_ctrl #(.PC_W(PC_W), .INT_EN(1'b1)) u_dutIntOn (
    .clk(clk), .resetn(resetn), .wb_valid(wb_valid), .wb_ready(wbReady0), .wb_pc(wb_pc),
    .wb_exc(wb_exc), .wb_ertn(wb_ertn), .wb_commit(wbCommit0), .has_int(has_int),
    .ex_entry(ex_entry), .ertn_pc(ertn_pc), .csr_wb_ex(csrWbEx0), .csr_ecode(ecode0),
    .csr_esubcode(esub0), .csr_pc(csrPc0), .csr_ertn_flush(ertnFlush0), .pipe_flush(pipeFlush0),
    .redirect_valid(redValid0), .redirect_target(redTarget0), .redirect_ready(redirect_ready)
  );

  exc_ctrl #(.PC_W(PC_W), .INT_EN(1'b0)) u_dutIntOff (
    .clk(clk), .resetn(resetn), .wb_valid(wb_valid), .wb_ready(wbReady1), .wb_pc(wb_pc),
    .wb_exc(wb_exc), .wb_ertn(wb_ertn), .wb_commit(wbCommit1), .has_int(has_int),
    .ex_entry(ex_entry), .ertn_pc(ertn_pc), .csr_wb_ex(csrWbEx1), .csr_ecode(ecode1),
    .csr_esubcode(esub1), .csr_pc(csrPc1), .csr_ertn_flush(ertnFlush1), .pipe_flush(pipeFlush1),
    .redirect_valid(redValid1), .redirect_target(redTarget1), .redirect_ready(redirect_ready)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCnt++;
    if (actual !== expected) begin
      errCnt++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic logic [5:0] refEcode(input logic [4:0] exc, input logic intP);
    logic [5:0] tab [5];
    tab[0] = 6'h08; tab[1] = 6'h0D; tab[2] = 6'h0B; tab[3] = 6'h0C; tab[4] = 6'h09;
    if (intP) return 6'h00;
    for (int i = 0; i < 5; i++) if (exc[i]) return tab[i];
    return 6'h00;
  endfunction

  function automatic logic intPending(input int d);
    return (d == 0) ? has_int : 1'b0;
  endfunction

  function automatic logic eventSeen(input int d);
    return wb_valid & (intPending(d) | (|wb_exc) | wb_ertn);
  endfunction

  task automatic compareAll(input int d, input outs_t e);
    string p;
    outs_t a;
    p = (d == 0) ? "intOn" : "intOff";
    a = obs[d];
    checkOutput({p, ".wb_ready"},       32'(a.wbReady),   32'(e.wbReady));
    checkOutput({p, ".wb_commit"},      32'(a.wbCommit),  32'(e.wbCommit));
    checkOutput({p, ".csr_wb_ex"},      32'(a.csrWbEx),   32'(e.csrWbEx));
    checkOutput({p, ".csr_ecode"},      32'(a.ecode),     32'(e.ecode));
    checkOutput({p, ".csr_esubcode"},   32'(a.esub),      32'(e.esub));
    checkOutput({p, ".csr_pc"},         a.csrPc,          e.csrPc);
    checkOutput({p, ".csr_ertn_flush"}, 32'(a.ertnFlush), 32'(e.ertnFlush));
    checkOutput({p, ".pipe_flush"},     32'(a.pipeFlush), 32'(e.pipeFlush));
    checkOutput({p, ".redirect_valid"}, 32'(a.redValid),  32'(e.redValid));
    if (e.redValid) checkOutput({p, ".redirect_target"}, a.redTarget, e.redTarget);
  endtask

  task automatic checkDut(input int d);
    outs_t e;
    e = '0;
    if (mAge[d] < 0) begin
      e.wbReady  = 1'b1;
      e.wbCommit = wb_valid & ~eventSeen(d);
    end else begin
      e.pipeFlush = 1'b1;
      if (mAge[d] == 1) begin
        if (mErtn[d]) e.ertnFlush = 1'b1;
        else begin
          e.csrWbEx = 1'b1;
          e.ecode   = mEcode[d];
          e.csrPc   = mPc[d];
        end
      end else if (mAge[d] >= 3) begin
        e.redValid  = 1'b1;
        e.redTarget = mTgt[d];
      end
    end
    compareAll(d, e);
  endtask

  task automatic advanceModel(input int d);
    if (mAge[d] < 0) begin
      if (eventSeen(d)) begin
        mAge[d]   = 1;
        mErtn[d]  = ~(intPending(d) | (|wb_exc));
        mEcode[d] = refEcode(wb_exc, intPending(d));
        mPc[d]    = wb_pc;
      end
    end else if (mAge[d] == 2) begin
      mAge[d] = 3;
      mTgt[d] = mErtn[d] ? ertn_pc : ex_entry;
    end else if (mAge[d] >= 3) begin
      if (redirect_ready) mAge[d] = -1;
      else                mAge[d] = mAge[d] + 1;
    end else begin
      mAge[d] = mAge[d] + 1;
    end
  endtask

  task automatic runCycle();
    @(negedge clk);
    checkDut(0);
    checkDut(1);
    advanceModel(0);
    advanceModel(1);
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [4:0] exc, input logic ertn,
                               input logic intr, input logic ready);
    wb_valid       = valid;
    wb_exc         = exc;
    wb_ertn        = ertn;
    has_int        = intr;
    redirect_ready = ready;
    runCycle();
  endtask

  initial begin
    resetn = 1'b0;
    wb_valid = 1'b0; wb_pc = '0; wb_exc = '0; wb_ertn = 1'b0; has_int = 1'b0;
    ex_entry = '0; ertn_pc = '0; redirect_ready = 1'b0;
    for (int d = 0; d < 2; d++) begin
      mAge[d] = -1; mErtn[d] = 1'b0; mEcode[d] = '0; mPc[d] = '0; mTgt[d] = '0;
    end

    repeat (2) runCycle();
    resetn = 1'b1;
    repeat (3) runCycle();

    // Plain instructions: every cycle commits.
    for (int i = 0; i < 10; i++) begin
      wb_pc = 32'h1C000000 + 32'(i * 4);
      applyStimulus(1'b1, 5'b00000, 1'b0, 1'b0, 1'b0);
    end

    // SYS exception with a 1-cycle handshake.
    wb_pc = 32'h1C000010; ex_entry = 32'h1C008000;
    applyStimulus(1'b1, 5'b00100, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 5'b00100, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 5'b00100, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 5'b00100, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 5'b00000, 1'b0, 1'b0, 1'b0);

    // ertn with a stalled redirect; the entry inputs move but the target must not.
    ertn_pc = 32'h1C000014; wb_pc = 32'h1C000020;
    applyStimulus(1'b1, 5'b00000, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 5'b00000, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 5'b00000, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      ertn_pc = 32'hDEAD0000 + 32'(i);
      applyStimulus(1'b0, 5'b00000, 1'b0, 1'b0, 1'b0);
    end
    applyStimulus(1'b0, 5'b00000, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 5'b00000, 1'b0, 1'b0, 1'b0);

    // Interrupt alongside ALE+INE: INT wins when enabled, INE otherwise.
    wb_pc = 32'h1C000040; ex_entry = 32'h1C009000;
    applyStimulus(1'b1, 5'b10010, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 5'b00000, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 5'b00000, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 5'b00000, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 5'b00000, 1'b0, 1'b0, 1'b0);

    // ertn together with ADEF: the exception wins.
    wb_pc = 32'h1C000050; ertn_pc = 32'h1C000060;
    applyStimulus(1'b1, 5'b00001, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 5'b00000, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 5'b00000, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 5'b00000, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 5'b00000, 1'b0, 1'b0, 1'b0);

    // Reset dropped while in WAIT abandons the event.
    wb_pc = 32'h1C000070;
    applyStimulus(1'b1, 5'b00100, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 5'b00000, 1'b0, 1'b0, 1'b0);
    resetn = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      outs_t e;
      e = '0;
      e.wbReady = 1'b1;
      mAge[d] = -1;
      compareAll(d, e);
    end
    repeat (2) runCycle();
    resetn = 1'b1;
    repeat (3) runCycle();

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      wb_pc    = $urandom();
      ex_entry = $urandom();
      ertn_pc  = $urandom();
      applyStimulus(1'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) == 0) ? 5'($urandom()) : 5'b00000,
                    1'($urandom_range(0, 5) == 0),
                    1'($urandom_range(0, 7) == 0),
                    1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errCnt, checkCnt);
    $finish;
  end

endmodule
